// File: rtl/multi_input_conditioner_if.sv
// Pin-side and conditioned-output bundle for multi_input_conditioner.
// Optional glitch_count lane exists only with MULTI_INPUT_CONDITIONER_GLITCH_COUNT_EN.
interface multi_input_conditioner_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   noisysignal;
    logic [CHANNELS-1:0]   conditioned;
    logic [CHANNELS-1:0]   positiveedge;
    logic [CHANNELS-1:0]   negativeedge;
    logic                  any_edge;
`ifdef MULTI_INPUT_CONDITIONER_GLITCH_COUNT_EN
    logic [8*CHANNELS-1:0] glitch_count;

    modport master (
        output noisysignal,
        input  conditioned, positiveedge, negativeedge, any_edge, glitch_count
    );
    modport slave (
        input  noisysignal,
        output conditioned, positiveedge, negativeedge, any_edge, glitch_count
    );
`else
    modport master (
        output noisysignal,
        input  conditioned, positiveedge, negativeedge, any_edge
    );
    modport slave (
        input  noisysignal,
        output conditioned, positiveedge, negativeedge, any_edge
    );
`endif
endinterface

// File: rtl/multi_input_conditioner.sv
// Per-channel synchroniser, counter debouncer and registered edge detector.
// Define MULTI_INPUT_CONDITIONER_GLITCH_COUNT_EN to add saturating rejected-glitch counters.
module multi_input_conditioner #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int WAIT_TIME     = 3,
    parameter int COUNTER_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    multi_input_conditioner_if.slave  bus
);
    localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(WAIT_TIME - 1);

    logic [CHANNELS-1:0]      sync_chain [SYNC_STAGES];
    logic [COUNTER_WIDTH-1:0] count      [CHANNELS];
    logic [CHANNELS-1:0]      sync;
    logic [CHANNELS-1:0]      diff;
    logic [CHANNELS-1:0]      fire;
    logic [CHANNELS-1:0]      cond_q;
    logic [CHANNELS-1:0]      pos_q;
    logic [CHANNELS-1:0]      neg_q;
    logic                     any_q;

    assign sync = sync_chain[SYNC_STAGES-1];

    // fire: the synchronised level has disagreed for the full wait window
    always_comb begin
        diff = sync ^ cond_q;
        fire = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            fire[i] = diff[i] && (count[i] == LAST_COUNT);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= '0;
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                count[i] <= '0;
            end
            cond_q <= '0;
            pos_q  <= '0;
            neg_q  <= '0;
            any_q  <= 1'b0;
        end else begin
            sync_chain[0] <= bus.noisysignal;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_chain[s] <= sync_chain[s-1];
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!diff[i] || fire[i]) begin
                    count[i] <= '0;
                end else begin
                    count[i] <= count[i] + 1'b1;
                end
            end
            cond_q <= cond_q ^ fire;
            pos_q  <= fire & sync;
            neg_q  <= fire & ~sync;
            any_q  <= |fire;
        end
    end

    assign bus.conditioned  = cond_q;
    assign bus.positiveedge = pos_q;
    assign bus.negativeedge = neg_q;
    assign bus.any_edge     = any_q;

`ifdef MULTI_INPUT_CONDITIONER_GLITCH_COUNT_EN
    logic [7:0] gcnt [CHANNELS];

    // A glitch is a return to the conditioned level while a count was running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                gcnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!diff[i] && (count[i] != '0) && (gcnt[i] != 8'hFF)) begin
                    gcnt[i] <= gcnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        bus.glitch_count = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            bus.glitch_count[8*i +: 8] = gcnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_multi_input_conditioner.sv
// Scoreboard bench for multi_input_conditioner: expected edge events are queued at
// stimulus time with a fixed SYNC_STAGES+WAIT_TIME latency and matched by a monitor.
module tb_multi_input_conditioner;
    localparam int CH  = 4;
    localparam int LAT = 5;

    typedef struct {
        int            cyc;
        logic [CH-1:0] pos;
        logic [CH-1:0] neg;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    ev_t  exp_q[$];

    multi_input_conditioner_if #(.CHANNELS(CH)) bus ();

    multi_input_conditioner #(
        .CHANNELS     (CH),
        .SYNC_STAGES  (2),
        .WAIT_TIME    (3),
        .COUNTER_WIDTH(3)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every nonzero pulse output must match the oldest queued event exactly
    always @(negedge clk) begin : monitor
        ev_t e;
        if (reset_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                vectors++;
                errors++;
                $display("FAIL missed_pulse cyc=%0d expected pos=%b neg=%b at cyc=%0d", cyc, e.pos, e.neg, e.cyc);
            end
            if (bus.positiveedge != '0 || bus.negativeedge != '0 || bus.any_edge) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d pos=%b neg=%b any=%b required none",
                             cyc, bus.positiveedge, bus.negativeedge, bus.any_edge);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || bus.positiveedge !== e.pos || bus.negativeedge !== e.neg
                        || bus.any_edge !== 1'b1) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d pos=%b neg=%b any=%b required cyc=%0d pos=%b neg=%b any=1",
                                 cyc, bus.positiveedge, bus.negativeedge, bus.any_edge, e.cyc, e.pos, e.neg);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if ({bus.conditioned, bus.positiveedge, bus.negativeedge, bus.any_edge} !== '0) begin
                errors++;
                $display("FAIL reset_hold outputs=%b required 0",
                         {bus.conditioned, bus.positiveedge, bus.negativeedge, bus.any_edge});
            end
        end
        reset_n = 1'b1;
        #1;
        vectors++;
        if ({bus.conditioned, bus.positiveedge, bus.negativeedge, bus.any_edge} !== '0) begin
            errors++;
            $display("FAIL reset_release outputs=%b required 0",
                     {bus.conditioned, bus.positiveedge, bus.negativeedge, bus.any_edge});
        end
`ifdef MULTI_INPUT_CONDITIONER_GLITCH_COUNT_EN
        vectors++;
        if (bus.glitch_count !== '0) begin
            errors++;
            $display("FAIL reset_glitch_count got=%h required 0", bus.glitch_count);
        end
`endif
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.conditioned !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle conditioned=%b required 0000", bus.conditioned);
        end
    endtask

    task automatic test_rise_ch0();
        @(negedge clk);
        bus.noisysignal[0] = 1'b1;
        exp_q.push_back('{cyc + LAT, 4'b0001, 4'b0000});
        repeat (LAT - 1) @(negedge clk);
        vectors++;
        if (bus.conditioned !== 4'b0000) begin
            errors++;
            $display("FAIL rise_early conditioned=%b required 0000", bus.conditioned);
        end
        @(negedge clk);
        vectors++;
        if (bus.conditioned !== 4'b0001) begin
            errors++;
            $display("FAIL rise_latency conditioned=%b required 0001", bus.conditioned);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL rise_drain pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_glitch_ch1();
        @(negedge clk);
        bus.noisysignal[1] = 1'b1;
        #25;
        bus.noisysignal[1] = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.conditioned !== 4'b0001) begin
            errors++;
            $display("FAIL glitch_reject conditioned=%b required 0001", bus.conditioned);
        end
`ifdef MULTI_INPUT_CONDITIONER_GLITCH_COUNT_EN
        vectors++;
        if (bus.glitch_count !== 32'h0000_0100) begin
            errors++;
            $display("FAIL glitch_count_ch1 got=%h required 00000100", bus.glitch_count);
        end
`endif
    endtask

    task automatic test_drop_ch2();
        @(negedge clk);
        bus.noisysignal[2] = 1'b1;
        exp_q.push_back('{cyc + LAT, 4'b0100, 4'b0000});
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.conditioned !== 4'b0101) begin
            errors++;
            $display("FAIL ch2_rise conditioned=%b required 0101", bus.conditioned);
        end
        @(negedge clk);
        bus.noisysignal[2] = 1'b0;
        #25;
        bus.noisysignal[2] = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.conditioned !== 4'b0101) begin
            errors++;
            $display("FAIL ch2_dropout conditioned=%b required 0101", bus.conditioned);
        end
`ifdef MULTI_INPUT_CONDITIONER_GLITCH_COUNT_EN
        vectors++;
        if (bus.glitch_count !== 32'h0001_0100) begin
            errors++;
            $display("FAIL glitch_count_ch2 got=%h required 00010100", bus.glitch_count);
        end
`endif
        @(negedge clk);
        bus.noisysignal[2] = 1'b0;
        exp_q.push_back('{cyc + LAT, 4'b0000, 4'b0100});
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.conditioned !== 4'b0001 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL ch2_fall conditioned=%b pending=%0d required 0001 pending 0",
                     bus.conditioned, exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int any_cycles;
        @(negedge clk);
        bus.noisysignal[0] = 1'b0;
        exp_q.push_back('{cyc + LAT, 4'b0000, 4'b0001});
        repeat (8) @(negedge clk);
        @(negedge clk);
        bus.noisysignal = 4'b1001;
        exp_q.push_back('{cyc + LAT, 4'b1001, 4'b0000});
        any_cycles = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.any_edge === 1'b1) any_cycles++;
        end
        vectors++;
        if (any_cycles !== 1) begin
            errors++;
            $display("FAIL simul_any_edge cycles=%0d required 1", any_cycles);
        end
        vectors++;
        if (bus.conditioned !== 4'b1001) begin
            errors++;
            $display("FAIL simul_level conditioned=%b required 1001", bus.conditioned);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.noisysignal[1] = ~bus.noisysignal[1];
            if (bus.noisysignal[1])
                exp_q.push_back('{cyc + LAT, 4'b0010, 4'b0000});
            else
                exp_q.push_back('{cyc + LAT, 4'b0000, 4'b0010});
            repeat (5) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (bus.conditioned !== 4'b1001 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b conditioned=%b pending=%0d required 1001 pending 0",
                     bus.conditioned, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_count();
        @(negedge clk);
        bus.noisysignal[0] = 1'b0;
        exp_q.push_back('{cyc + LAT, 4'b0000, 4'b0001});
        repeat (8) @(negedge clk);
        @(negedge clk);
        bus.noisysignal[0] = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.conditioned, bus.positiveedge, bus.negativeedge, bus.any_edge} !== '0) begin
            errors++;
            $display("FAIL midreset_clear outputs=%b required 0",
                     {bus.conditioned, bus.positiveedge, bus.negativeedge, bus.any_edge});
        end
`ifdef MULTI_INPUT_CONDITIONER_GLITCH_COUNT_EN
        vectors++;
        if (bus.glitch_count !== '0) begin
            errors++;
            $display("FAIL midreset_glitch_count got=%h required 0", bus.glitch_count);
        end
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back('{cyc + LAT, 4'b1001, 4'b0000});
        repeat (LAT - 1) @(negedge clk);
        vectors++;
        if (bus.conditioned !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_early conditioned=%b required 0000", bus.conditioned);
        end
        @(negedge clk);
        vectors++;
        if (bus.conditioned !== 4'b1001) begin
            errors++;
            $display("FAIL midreset_rise conditioned=%b required 1001", bus.conditioned);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL midreset_drain pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        bus.noisysignal = '0;
        test_reset();
        test_rise_ch0();
        test_glitch_ch1();
        test_drop_ch2();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/multi_input_conditioner.md
Name: multi_input_conditioner

Overview:
Parametrised, multi-channel successor to the single-bit input conditioner. Each of CHANNELS asynchronous noisy inputs passes through three stages:
- an N-stage synchroniser;
- a counter-based debouncer with a programmable wait time;
- a registered rising/falling edge detector.

It sits between board-level switch/button pins and synchronous control logic. It also provides an OR-reduced any-edge strobe for an interrupt or wake source.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flip-flop depth per channel (>=2)
WAIT_TIME, 3, consecutive clock edges a synchronised input must differ from conditioned before conditioned follows (>=1)
COUNTER_WIDTH, 3, debounce counter width; must satisfy 2^COUNTER_WIDTH > WAIT_TIME

Ports:
clk  input  1  system clock; all state on rising edge
reset_n  input  1  asynchronous, active-low reset
noisysignal  input  CHANNELS  raw asynchronous inputs, bit i = channel i
conditioned  output  CHANNELS  synchronised, debounced level per channel
positiveedge  output  CHANNELS  one-cycle pulse when conditioned[i] goes 0->1
negativeedge  output  CHANNELS  one-cycle pulse when conditioned[i] goes 1->0
any_edge  output  1  registered OR of all positiveedge|negativeedge, same cycle as those pulses
glitch_count  output  8*CHANNELS  only with GLITCH_COUNT_EN; channel i at bits [8i+7:8i]

Behaviour:
- Interface clocking and reset:
  - one clock, clk;
  - reset is asynchronous and active-low (reset_n);
  - assertion clears all state immediately, independent of clk.
- Reset values (all zero):
  - all synchroniser stages, debounce counters, conditioned, positiveedge, negativeedge, any_edge = 0;
  - glitch_count = 0 when present.
- Reset mid-operation: an in-progress count is discarded and no edge pulse is produced. After release, a channel whose input is held at 1 rises normally after the full latency, including a positiveedge pulse.
- Synchroniser: per channel, a shift chain of SYNC_STAGES flops; sync[i] is the last stage. No combinational path from noisysignal to any output.
- Debounce, per channel, evaluated each rising clk edge:
  - sync == conditioned: counter <= 0.
  - sync != conditioned and counter == WAIT_TIME-1: conditioned <= sync, counter <= 0, and the matching edge pulse register <= 1.
  - otherwise: counter <= counter + 1.
- Latency: an input level held stable across the required window appears on conditioned exactly SYNC_STAGES+WAIT_TIME rising edges after the first edge that samples it.
- Glitch rejection:
  - a synchronised excursion shorter than WAIT_TIME edges never changes conditioned;
  - if sync returns to conditioned mid-count, the counter restarts from 0 and the count does not accumulate across excursions.
- Edge pulses:
  - registered; asserted in the same cycle conditioned first shows its new value;
  - high for exactly one cycle; otherwise 0;
  - positiveedge and negativeedge are never high together on the same channel.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses; any_edge is a single-cycle 1 in that cycle.
- Back-to-back toggling slower than the debounce window yields alternating pulses with no lost edges. The minimum pulse spacing on one channel is WAIT_TIME cycles.

Optional Feature:
- Macro: MULTI_INPUT_CONDITIONER_GLITCH_COUNT_EN.
- Defined:
  - the glitch_count port exists;
  - per channel, an 8-bit counter increments when sync returns to conditioned while the debounce counter is nonzero (a rejected glitch);
  - the counter saturates at 255;
  - it is cleared only by reset_n.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Defaults, 20 ns clock: reset_n=0 for 2 cycles, noisysignal=0 -> all outputs 0, including during reset and through the async release.
- Channel 0 rises and holds -> conditioned[0]=1 after exactly 5 edges; positiveedge[0] and any_edge are 1 for one cycle; other channels stay 0.
- Channel 1 gets a 25 ns high pulse (spanning 1-2 edges) -> conditioned[1] stays 0, no pulses; with the macro defined, glitch_count[15:8]=1.
- Channel 2 held 1 for 200 ns, then dropped 0 for 25 ns, then back to 1 -> conditioned[2] stays 1, no negativeedge; then 0 held for 200 ns -> one negativeedge[2] pulse 5 edges after the drop.
- Channels 0 and 3 rise on the same edge -> positiveedge=4'b1001 in a single cycle; any_edge is 1 for exactly one cycle.
- reset_n pulsed low 2 edges into a debounce count with input held 1 -> outputs 0 immediately; after release, conditioned rises 5 edges later with one positiveedge pulse.
